// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity bit, one or two stop bits.
// The parity state and parity logic are built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  data_ack,
  output logic                  busy,
  output logic                  tx_out
);
  localparam int               CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    ack_q, ack_d;
  logic                    accept_s;

`ifdef UART_TX_PARITY_EN
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`else
  logic                    unused_par_s;
  assign unused_par_s = par_en ^ par_typ;
`endif

  // A word is taken on a tick from IDLE or from the final stop-bit tick
  always_comb begin
    accept_s = 1'b0;
    if (baud_tick && data_valid) begin
      accept_s = (state_q == S_IDLE) ||
                 ((state_q == S_STOP) && (stop_cnt_q == LAST_STOP));
    end else begin
      accept_s = 1'b0;
    end
  end

  // Frame sequencing; every transition waits for a baud tick
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    if (accept_s) begin
      state_d    = S_START;
      shift_d    = p_data;
      bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
      par_en_d   = par_en;
      par_bit_d  = calc_parity(p_data, par_typ);
`endif
    end else if (baud_tick) begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_START: begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
        S_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d    = par_en_q ? S_PARITY : S_STOP;
`else
            state_d    = S_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
        S_STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output values are derived from the next state so the pins are registered
  always_comb begin
    busy_d = (state_d != S_IDLE);
    ack_d  = accept_s;
    tx_d   = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_bit_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset drops any frame in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign data_ack = ack_q;

endmodule
